alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_alu_pipe.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready ALU with a registered result and S/Z/C/V flags.
// Define ALU_PIPE_MUL_EN to add op 7, an iterative shift-add multiplier.
module alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             S,
    output logic             Z,
    output logic             C,
    output logic             V
);
    localparam int SW = $clog2(WIDTH);

`ifdef ALU_PIPE_MUL_EN
    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, HOLD} state_t;
`endif

    state_t           state_q, state_d, accept_state;
    logic             accept, is_mul_op, mul_done, mul_c;
    logic [WIDTH-1:0] mul_res;
    logic [WIDTH-1:0] res_q, res_d;
    logic             s_q, s_d, z_q, z_d, c_q, c_d, v_q, v_d;

    assign accept = in_valid && in_ready;

    // Single-cycle ALU
    logic [SW-1:0]    sh_n;
    logic [WIDTH:0]   add_full, sub_full, sll_full, srl_full;
    logic [WIDTH-1:0] ror_full, alu_res;
    logic             alu_c, alu_v;

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sh_n     = b[SW-1:0];
        add_full = {1'b0, a} + {1'b0, b};
        sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        sll_full = {1'b0, a} << sh_n;
        srl_full = {a, 1'b0} >> sh_n;
        ror_full = WIDTH'({a, a} >> sh_n);
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (op)
            4'd0: begin
                alu_res = add_full[WIDTH-1:0];
                alu_c   = add_full[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
            end
            4'd1, 4'd5: begin
                alu_res = sub_full[WIDTH-1:0];
                alu_c   = sub_full[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
            end
            4'd2:               alu_res = a & b;
            4'd3:               alu_res = a | b;
            4'd4:               alu_res = a ^ b;
            4'd6, 4'd12, 4'd15: alu_res = add_full[WIDTH-1:0];
            4'd8: begin
                alu_res = sll_full[WIDTH-1:0];
                alu_c   = sll_full[WIDTH];
            end
            4'd9:               alu_res = ror_full;
            4'd10: begin
                alu_res = srl_full[WIDTH:1];
                alu_c   = srl_full[0];
            end
            4'd11: begin
                alu_res = $unsigned($signed(a) >>> sh_n);
                alu_c   = srl_full[0];
            end
            default: ;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SW-1:0]      cnt_q, cnt_d;

    assign is_mul_op    = (op == 4'd7);
    assign accept_state = is_mul_op ? MUL : HOLD;
    assign mul_done     = (state_q == MUL) && (cnt_q == SW'(WIDTH - 1));
    assign mul_res      = acc_d[WIDTH-1:0];
    assign mul_c        = |acc_d[2*WIDTH-1:WIDTH];

    // One multiplier bit per cycle; operands are frozen at accept.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (accept && is_mul_op) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (state_q == MUL) begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    // NOTE: multiplier registers are reset too, so an aborted multiply leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    assign is_mul_op    = 1'b0;
    assign accept_state = HOLD;
    assign mul_done     = 1'b0;
    assign mul_res      = '0;
    assign mul_c        = 1'b0;
`endif

    // NOTE: clocked blocks use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = accept_state;
`ifdef ALU_PIPE_MUL_EN
            MUL:  if (mul_done) state_d = HOLD;
`endif
            HOLD: if (out_ready) state_d = in_valid ? accept_state : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
        out_valid = (state_q == HOLD);
    end

    // Result register loads on a single-cycle accept or on multiply completion.
    always_comb begin
        res_d = res_q;
        s_d   = s_q;
        z_d   = z_q;
        c_d   = c_q;
        v_d   = v_q;
        if (accept && !is_mul_op) begin
            res_d = alu_res;
            c_d   = alu_c;
            v_d   = alu_v;
            s_d   = alu_res[WIDTH-1];
            z_d   = (alu_res == '0);
        end else if (mul_done) begin
            res_d = mul_res;
            c_d   = mul_c;
            v_d   = 1'b0;
            s_d   = mul_res[WIDTH-1];
            z_d   = (mul_res == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            s_q   <= 1'b0;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
        end else begin
            res_q <= res_d;
            s_q   <= s_d;
            z_q   <= z_d;
            c_q   <= c_d;
            v_q   <= v_d;
        end
    end

    assign res = res_q;
    assign S   = s_q;
    assign Z   = z_q;
    assign C   = c_q;
    assign V   = v_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: a 16-bit and an 8-bit instance against an arithmetic reference model.
// Multiply checks are compiled in when ALU_PIPE_MUL_EN is defined.
module tb_alu_pipe;
`ifdef ALU_PIPE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct {
        logic [63:0] res;
        bit          s, z, c, v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [3:0]  op = '0;
    logic [15:0] a = '0, b = '0, res;
    logic        S, Z, C, V;

    logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0;
    logic [3:0]  op8 = '0;
    logic [7:0]  a8 = '0, b8 = '0, res8;
    logic        S8, Z8, C8, V8;

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .res(res),
        .S(S), .Z(Z), .C(C), .V(V)
    );

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .res(res8),
        .S(S8), .Z(Z8), .C(C8), .V(V8)
    );

    // Reference: plain integer arithmetic on w-bit values held in 64-bit variables.
    function automatic exp_t model(input int w, input int opc,
                                   input longint unsigned av, input longint unsigned bv);
        exp_t e;
        longint unsigned mask, full;
        longint sa, sb, sr, smax, smin;
        int n;
        mask = (64'd1 << w) - 64'd1;
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        sa   = av[w-1] ? longint'(av) - (longint'(1) << w) : longint'(av);
        sb   = bv[w-1] ? longint'(bv) - (longint'(1) << w) : longint'(bv);
        n    = int'(bv & 64'(w - 1));
        e.res = '0;
        e.c   = 1'b0;
        e.v   = 1'b0;
        case (opc)
            0: begin
                full  = av + bv;
                e.res = full & mask;
                e.c   = ((full >> w) & 64'd1) != 64'd0;
                sr    = sa + sb;
                e.v   = (sr > smax) || (sr < smin);
            end
            1, 5: begin
                e.res = (av - bv) & mask;
                e.c   = av >= bv;
                sr    = sa - sb;
                e.v   = (sr > smax) || (sr < smin);
            end
            2: e.res = av & bv;
            3: e.res = av | bv;
            4: e.res = av ^ bv;
            6, 12, 15: e.res = (av + bv) & mask;
            7: if (MUL_EN) begin
                full  = av * bv;
                e.res = full & mask;
                e.c   = (full >> w) != 64'd0;
            end
            8: begin
                e.res = (av << n) & mask;
                e.c   = (n > 0) && (((av >> (w - n)) & 64'd1) != 64'd0);
            end
            9: e.res = ((av >> n) | (av << (w - n))) & mask;
            10: begin
                e.res = av >> n;
                e.c   = (n > 0) && (((av >> (n - 1)) & 64'd1) != 64'd0);
            end
            11: begin
                e.res = $unsigned(sa >>> n) & mask;
                e.c   = (n > 0) && (((av >> (n - 1)) & 64'd1) != 64'd0);
            end
            default: ;
        endcase
        e.s = e.res[w-1];
        e.z = (e.res == 64'd0);
        return e;
    endfunction

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    // One cycle on the 16-bit instance, entered and left at a falling edge.
    task automatic cycle16(input bit iv, input logic [3:0] o, input logic [15:0] av,
                           input logic [15:0] bv, input bit ordy);
        bit acc, del;
        exp_t e;
        in_valid  = iv;
        op        = o;
        a         = av;
        b         = bv;
        out_ready = ordy;
        #1;
        checks++;
        if (out_valid !== (sb_q.size() != 0)) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b", out_valid, sb_q.size() != 0);
        end
        checks++;
        if (in_ready !== ((sb_q.size() == 0) || ordy)) begin
            errors++;
            $display("FAIL in_ready: got %b expected %b", in_ready, (sb_q.size() == 0) || ordy);
        end
        if (sb_q.size() != 0) begin
            e = sb_q[0];
            checks++;
            if ({res, S, Z, C, V} !== {e.res[15:0], e.s, e.z, e.c, e.v}) begin
                errors++;
                $display("FAIL result16: got res=%h SZCV=%b%b%b%b expected res=%h SZCV=%b%b%b%b",
                         res, S, Z, C, V, e.res[15:0], e.s, e.z, e.c, e.v);
            end
        end
        acc = iv && ((sb_q.size() == 0) || ordy);
        del = (sb_q.size() != 0) && ordy;
        @(posedge clk);
        if (del) void'(sb_q.pop_front());
        if (acc) sb_q.push_back(model(16, int'(o), 64'(av), 64'(bv)));
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({out_valid, res, S, Z, C, V, in_ready} !== {1'b0, 16'h0, 4'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset16: got ov=%b res=%h SZCV=%b%b%b%b rdy=%b expected 0 0000 0000 1",
                     out_valid, res, S, Z, C, V, in_ready);
        end
        checks++;
        if ({out_valid8, res8, S8, Z8, C8, V8, in_ready8} !== {1'b0, 8'h0, 4'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset8: got ov=%b res=%h SZCV=%b%b%b%b rdy=%b expected 0 00 0000 1",
                     out_valid8, res8, S8, Z8, C8, V8, in_ready8);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed16();
        cycle16(1'b1, 4'd0, 16'h7FFF, 16'h0001, 1'b1);
        checks++;
        if ({out_valid, res, S, Z, C, V} !== {1'b1, 16'h8000, 4'b1001}) begin
            errors++;
            $display("FAIL add_ovf: got ov=%b res=%h SZCV=%b%b%b%b expected 1 8000 1001",
                     out_valid, res, S, Z, C, V);
        end
        cycle16(1'b1, 4'd1, 16'h0000, 16'h0001, 1'b1);
        checks++;
        if ({res, S, C, V} !== {16'hFFFF, 3'b100}) begin
            errors++;
            $display("FAIL sub_borrow: got res=%h SCV=%b%b%b expected FFFF 100", res, S, C, V);
        end
        cycle16(1'b1, 4'd1, 16'h0005, 16'h0005, 1'b1);
        checks++;
        if ({res, Z, C} !== {16'h0000, 2'b11}) begin
            errors++;
            $display("FAIL sub_zero: got res=%h ZC=%b%b expected 0000 11", res, Z, C);
        end
        cycle16(1'b1, 4'd7, 16'h1234, 16'h0002, 1'b1);
        if (!MUL_EN) begin
            checks++;
            if ({res, Z, C, V} !== {16'h0000, 3'b100}) begin
                errors++;
                $display("FAIL op7_undef: got res=%h ZCV=%b%b%b expected 0000 100", res, Z, C, V);
            end
            cycle16(1'b0, 4'd0, 16'h0, 16'h0, 1'b1);
        end else begin
            // The multiply is checked separately; let it run out quietly.
            in_valid = 1'b0;
            repeat (20) @(posedge clk);
            @(negedge clk);
            sb_q.delete();
        end
        cycle16(1'b0, 4'd0, 16'h0, 16'h0, 1'b1);
    endtask

    task automatic test_width8();
        logic [3:0] ops[3] = '{4'd11, 4'd8, 4'd9};
        logic [7:0] av[3]  = '{8'h81, 8'h81, 8'h01};
        logic [7:0] bv[3]  = '{8'h01, 8'h09, 8'h01};
        logic [7:0] er[3]  = '{8'hC0, 8'h02, 8'h80};
        bit         ec[3]  = '{1'b1, 1'b1, 1'b0};
        exp_t e;
        for (int i = 0; i < 43; i++) begin
            in_valid8  = 1'b1;
            out_ready8 = 1'b1;
            if (i < 3) begin
                op8 = ops[i]; a8 = av[i]; b8 = bv[i];
            end else begin
                op8 = 4'($urandom_range(0, 15));
                if (MUL_EN && op8 == 4'd7) op8 = 4'd0;
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
            e = model(8, int'(op8), 64'(a8), 64'(b8));
            @(posedge clk);
            @(negedge clk);
            in_valid8 = 1'b0;
            if (i < 3) begin
                checks++;
                if ({res8, C8} !== {er[i], ec[i]}) begin
                    errors++;
                    $display("FAIL w8_vec%0d: got res=%h C=%b expected %h %b", i, res8, C8, er[i], ec[i]);
                end
            end
            checks++;
            if ({out_valid8, res8, S8, Z8, C8, V8} !== {1'b1, e.res[7:0], e.s, e.z, e.c, e.v}) begin
                errors++;
                $display("FAIL w8_op%0d: got ov=%b res=%h SZCV=%b%b%b%b expected 1 %h %b%b%b%b",
                         op8, out_valid8, res8, S8, Z8, C8, V8, e.res[7:0], e.s, e.z, e.c, e.v);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] held;
        for (int i = 0; i < 4; i++) cycle16(1'b1, 4'd0, pick16(), pick16(), 1'b1);
        held = res;
        cycle16(1'b1, 4'd0, 16'h1111, 16'h2222, 1'b0);
        cycle16(1'b1, 4'd0, 16'h3333, 16'h4444, 1'b0);
        checks++;
        if ({out_valid, in_ready, res} !== {1'b1, 1'b0, held}) begin
            errors++;
            $display("FAIL stall_hold: got ov=%b rdy=%b res=%h expected 1 0 %h", out_valid, in_ready, res, held);
        end
        cycle16(1'b0, 4'd0, 16'h0, 16'h0, 1'b1);
        cycle16(1'b0, 4'd0, 16'h0, 16'h0, 1'b1);
    endtask

    task automatic test_random();
        logic [3:0] o;
        for (int i = 0; i < 400; i++) begin
            o = 4'($urandom_range(0, 15));
            if (MUL_EN && o == 4'd7) o = 4'd1;
            cycle16($urandom_range(0, 3) != 0, o, pick16(), pick16(), $urandom_range(0, 3) != 0);
        end
        cycle16(1'b0, 4'd0, 16'h0, 16'h0, 1'b1);
        cycle16(1'b0, 4'd0, 16'h0, 16'h0, 1'b1);
    endtask

    task automatic test_reset_hold();
        cycle16(1'b1, 4'd3, 16'h00F0, 16'h0F00, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        rst_n     = 1'b0;
        #1;
        checks++;
        if ({out_valid, res, S, Z, C, V, in_ready} !== {1'b0, 16'h0, 4'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_hold: got ov=%b res=%h SZCV=%b%b%b%b rdy=%b expected 0 0000 0000 1",
                     out_valid, res, S, Z, C, V, in_ready);
        end
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cycle16(1'b1, 4'd4, 16'hA5A5, 16'h0FF0, 1'b1);
        cycle16(1'b0, 4'd0, 16'h0, 16'h0, 1'b1);
        cycle16(1'b0, 4'd0, 16'h0, 16'h0, 1'b1);
    endtask

`ifdef ALU_PIPE_MUL_EN
    task automatic test_mul();
        logic [15:0] ma[6] = '{16'h0100, 16'hFFFF, 16'h0003, 16'h1234, 16'h0000, 16'h8001};
        logic [15:0] mb[6] = '{16'h0100, 16'hFFFF, 16'h0005, 16'h00FF, 16'h7777, 16'h0002};
        exp_t e;
        int edges;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; op = 4'd7; a = ma[i]; b = mb[i]; out_ready = 1'b1;
            e = model(16, 7, 64'(ma[i]), 64'(mb[i]));
            @(posedge clk);
            edges = 1;
            @(negedge clk);
            op = 4'd0; a = 16'($urandom); b = 16'($urandom);
            while (edges < 40) begin
                @(posedge clk);
                edges++;
                #1;
                if (out_valid) break;
            end
            in_valid = 1'b0;
            checks++;
            if (edges != 17) begin
                errors++;
                $display("FAIL mul_latency%0d: got %0d edges expected 17", i, edges);
            end
            checks++;
            if ({res, S, Z, C, V} !== {e.res[15:0], e.s, e.z, e.c, e.v}) begin
                errors++;
                $display("FAIL mul%0d: got res=%h SZCV=%b%b%b%b expected %h %b%b%b%b",
                         i, res, S, Z, C, V, e.res[15:0], e.s, e.z, e.c, e.v);
            end
            if (i == 0) begin
                checks++;
                if ({res, Z, C} !== {16'h0000, 2'b11}) begin
                    errors++;
                    $display("FAIL mul_0100: got res=%h ZC=%b%b expected 0000 11", res, Z, C);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_mul_reset();
        bit seen = 1'b0;
        in_valid = 1'b1; op = 4'd7; a = 16'h0100; b = 16'h0100; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL mul_abort: got ov=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mul_discard: got seen_valid=%b rdy=%b expected 0 1", seen, in_ready);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed16();
        test_width8();
        test_back_to_back();
        test_random();
        test_reset_hold();
`ifdef ALU_PIPE_MUL_EN
        test_mul();
        test_mul_reset();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
